// File: rtl/prio_enc_drain.sv
// prio_enc_drain: captures a request vector and emits one encoded index per set bit, MSB-first (LSB-first with PRIO_ENC_LSB_FIRST_EN).
// Latency: first beat is presented one cycle after acceptance; then one beat per cycle while out_ready is high.
// Backpressure: out_ready low freezes idx/v/last and pend; in_ready is low for the whole drain, and in_valid is ignored meanwhile.
module prio_enc_drain #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] D,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] idx,
  output logic         v,
  output logic         last,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   pend;
  logic [N-1:0]   pend_clr;
  logic [W-1:0]   idx_clr;
  logic           accept;
  logic           beat;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Priority pick: the winning bit is the last one visited by the loop.
  function automatic logic [W-1:0] pick(input logic [N-1:0] vec);
    logic [W-1:0] r;
    r = '0;
`ifdef PRIO_ENC_LSB_FIRST_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) r = W'(i);
    end
`else
    for (int i = 0; i < N; i++) begin
      if (vec[i]) r = W'(i);
    end
`endif
    return r;
  endfunction

  function automatic logic onehot(input logic [N-1:0] vec);
    return (vec != '0) && ((vec & (vec - ONE)) == '0);
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DRAIN);
  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;

  // Pending vector with the bit being emitted removed, and the index that follows it.
  always_comb begin
    pend_clr = pend & ~(ONE << idx);
    idx_clr  = pick(pend_clr);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: drain starts on acceptance and ends on the handshake of the last beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRAIN;
      DRAIN:   if (beat && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, advance to the next pending bit on each non-final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      idx  <= '0;
      v    <= 1'b0;
      last <= 1'b0;
    end else if (accept) begin
      pend <= D;
      idx  <= pick(D);
      v    <= (D != '0);
      last <= (D == '0) || onehot(D);
    end else if (beat) begin
      if (last) begin
        pend <= '0;
        idx  <= '0;
        v    <= 1'b0;
        last <= 1'b0;
      end else begin
        pend <= pend_clr;
        idx  <= idx_clr;
        last <= onehot(pend_clr);
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_drain.sv
// Bench for prio_enc_drain (N=8): directed vectors, expected beats queued at issue time, monitor compares on each presented beat.
// Inputs are driven 1 time unit after the rising edge; the monitor samples on the falling edge.
// Reorders its expected beats when PRIO_ENC_LSB_FIRST_EN is defined.
module tb_prio_enc_drain;

  localparam int N = 8;
  localparam int W = 3;

  typedef struct packed {
    logic [W-1:0] idx;
    logic         v;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] D;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] idx;
  logic         v;
  logic         last;
  logic         out_valid;
  logic         out_ready;

  beat_t sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  prio_enc_drain #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .D         (D),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .idx       (idx),
    .v         (v),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input int i, input logic vv, input logic ll);
    beat_t b;
    b.idx  = W'(i);
    b.v    = vv;
    b.last = ll;
    sb.push_back(b);
  endtask

  task automatic send(input logic [N-1:0] vec);
    D        = vec;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || out_valid) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_chk++;
    if (k < 50) n_pass++;
    else $display("FAIL %s_timeout: %0d beats still queued, out_valid=%0b, required drained", name, sb.size(), out_valid);
  endtask

  // Monitor: every presented beat is compared with the head of the scoreboard; popped only on handshake.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got idx=%0d v=%0b last=%0b, expected no beat", idx, v, last);
      end else begin
        e = sb[0];
        if (out_ready) void'(sb.pop_front());
        check(out_ready ? "beat" : "beat_hold", {27'd0, idx, v, last}, {27'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    D         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_idx",       {29'd0, idx},       32'd0);
    check("rst_v",         {31'd0, v},         32'd0);
    check("rst_last",      {31'd0, last},      32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All-zero vector: single beat idx=0 v=0 last=1.
    push(0, 1'b0, 1'b1);
    send(8'b0000_0000);
    wait_drain("zero");
    check("zero_in_ready", {31'd0, in_ready}, 32'd1);

    // Single request, first beat one cycle after acceptance.
    push(7, 1'b1, 1'b1);
    send(8'b1000_0000);
    check("single_latency", {31'd0, out_valid}, 32'd1);
    wait_drain("single");

    // Multi-bit vector at full throughput.
`ifdef PRIO_ENC_LSB_FIRST_EN
    push(0, 1'b1, 1'b0); push(4, 1'b1, 1'b0); push(5, 1'b1, 1'b0); push(7, 1'b1, 1'b1);
`else
    push(7, 1'b1, 1'b0); push(5, 1'b1, 1'b0); push(4, 1'b1, 1'b0); push(0, 1'b1, 1'b1);
`endif
    send(8'b1011_0001);
    wait_drain("multi");

    // Backpressure: first beat held for 3 stalled cycles, then accepted.
`ifdef PRIO_ENC_LSB_FIRST_EN
    push(4, 1'b1, 1'b0); push(6, 1'b1, 1'b1);
`else
    push(6, 1'b1, 1'b0); push(4, 1'b1, 1'b1);
`endif
    out_ready = 1'b0;
    send(8'b0101_0000);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("stall");

    // Reset in the middle of a drain after three beats.
`ifdef PRIO_ENC_LSB_FIRST_EN
    push(0, 1'b1, 1'b0); push(1, 1'b1, 1'b0); push(2, 1'b1, 1'b0); push(3, 1'b1, 1'b0);
`else
    push(7, 1'b1, 1'b0); push(6, 1'b1, 1'b0); push(5, 1'b1, 1'b0); push(4, 1'b1, 1'b0);
`endif
    send(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_beats_done", sb.size(), 32'd1);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mid_rst_last",      {31'd0, last},      32'd0);
    repeat (3) @(posedge clk);
    #1;
    push(0, 1'b1, 1'b1);
    send(8'h01);
    wait_drain("post_rst");

    // in_valid with changing D during drain, including the last-beat cycle, must be ignored.
`ifdef PRIO_ENC_LSB_FIRST_EN
    push(1, 1'b1, 1'b0); push(2, 1'b1, 1'b0); push(5, 1'b1, 1'b1);
`else
    push(5, 1'b1, 1'b0); push(2, 1'b1, 1'b0); push(1, 1'b1, 1'b1);
`endif
    send(8'b0010_0110);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      D        = (k == 0) ? 8'hFF : (k == 1) ? 8'h81 : 8'h3C;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("ignore_in_ready", {31'd0, in_ready}, 32'd1);
    wait_drain("ignore");
    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", sb.size(), 32'd0);
    check("final_idle", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
